max_pool_stream: RTL
====================

# max_pool_stream

Parametrised streaming max/average pooling stage for the CNN datapath. Consumes a raster-order feature map (multi-bit pixels, several channels in parallel), reduces each non-overlapping POOL×POOL window to one value per channel, and emits the pooled map in raster order. It sits directly after the convolution/activation stage and feeds the next layer or the dense stage. It replaces the 1-bit, fixed 2×2 window buffer and includes the reduction itself.

## Interface
- DATA_W, 8, bits per channel sample
- CHANNELS, 1, channels carried side by side on one bus
- WIDTH, 26, input columns per row
- HEIGHT, 26, input rows per frame
- POOL, 2, window size and stride (power of two, 2..8)
- SIGNED, 0, 1 = samples are two's complement for compare/sum
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- avg_mode  in  1  0 = max pooling, 1 = average pooling; sampled only at start of frame
- valid_in  in  1  pixel_in is valid this cycle
- sof_in  in  1  qualified by valid_in; this pixel is input (0,0)
- pixel_in  in  CHANNELS*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- valid_out  out  1  pixel_out is valid (one-cycle pulse per pooled pixel)
- pixel_out  out  CHANNELS*DATA_W  pooled result, same packing
- last_out  out  1  with valid_out: last pooled pixel of frame
- ox_out  out  $clog2(WIDTH/POOL)  pooled column of pixel_out
- oy_out  out  $clog2(HEIGHT/POOL)  pooled row of pixel_out

## Operation
- Counters x (0..WIDTH-1), y (0..HEIGHT-1) advance on each valid_in; x wraps to 0 and y increments; y wraps to 0 after the last pixel of a frame. No handshake back to the source; valid_in gaps freeze all state.
- sof_in with valid_in forces the current pixel to be treated as (0,0), whatever the counters hold. The counters continue from (1,0) and partial accumulations are discarded. A mid-frame sof_in aborts the old frame without output.
- The active mode is latched when the pixel at (0,0) is accepted. Changes to avg_mode mid-frame have no effect.
- Per channel there is a horizontal accumulator h and a row store of OW = WIDTH/POOL entries.
  - Max mode: h holds the running max.
  - Avg mode: h holds the running sum, width DATA_W + 2*log2(POOL).
  - Comparison and sum are signed when SIGNED=1.
- At column phase x%POOL == POOL-1, h merges into store[x/POOL]. The first row of a band (y%POOL == 0) overwrites the entry; later rows combine with it.
- At y%POOL == POOL-1 and x%POOL == POOL-1, the merged value is the result.
  - Max mode: the value as is.
  - Avg mode: sum arithmetic-shifted right by 2*log2(POOL) (floor; arithmetic shift when SIGNED).
  - Output is truncated to DATA_W.
- Columns x >= OW*POOL and rows y >= OH*POOL (OH = HEIGHT/POOL) are accepted and ignored (floor behaviour).
- last_out is asserted with the output for ox = OW-1, oy = OH-1.
- Reset: x, y, h and mode are cleared; valid_out, last_out, pixel_out, ox_out and oy_out are all 0. The row store need not be cleared, because the first band row overwrites it.

## Timing
- Latency: valid_out rises exactly 1 cycle after the valid_in cycle that carries the window's bottom-right pixel.
- valid_out is high for exactly one cycle. Between outputs, pixel_out, ox_out and oy_out hold 0.
- Throughput: one input pixel per cycle sustained, with no stall.
- A window completion coinciding with sof_in: sof_in wins, and no output is produced for the aborted window.
- rst_n low on any edge overrides valid_in. An output pending from the previous cycle is suppressed.

## Test plan
- Max mode, DATA_W=8, 4×4 frame, pixel = y*4+x: outputs 5, 7, 13, 15 at (0,0), (1,0), (0,1), (1,1). last_out is set only with 15. Each valid_out comes 1 cycle after input pixels 5, 7, 13, 15.
- Avg mode, same frame: outputs 2, 4, 10, 12 (sums 10, 18, 42, 50 >> 2).
- SIGNED=1, CHANNELS=2, max mode, ch0 all −3 except one −1 per window, ch1 = −128 everywhere: ch0 = 0xFF and ch1 = 0x80 in every output.
- WIDTH=5, HEIGHT=5, POOL=2, random valid_in gaps: exactly 4 outputs, and pixels in column 4 / row 4 never influence a result. Results match the gap-free run.
- sof_in asserted at input (3,1) of a 4×4 frame, then a full frame follows: no output from the aborted frame, and the next 4 outputs are correct for the new frame.
- rst_n low for 1 cycle in the same cycle as a window-completing pixel: valid_out stays 0. After release, a full frame produces 4 correct outputs.

Source files
------------

// File: rtl/max_pool_stream.sv
// Streaming POOL x POOL max/average pooling over a raster-order, multi-channel feature map.
// One pooled pixel per completed window, registered one cycle after its bottom-right input.
module max_pool_stream #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 1,
    parameter int WIDTH    = 26,
    parameter int HEIGHT   = 26,
    parameter int POOL     = 2,
    parameter int SIGNED   = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            avg_mode,
    input  logic                            valid_in,
    input  logic                            sof_in,
    input  logic [CHANNELS*DATA_W-1:0]      pixel_in,
    output logic                            valid_out,
    output logic [CHANNELS*DATA_W-1:0]      pixel_out,
    output logic                            last_out,
    output logic [$clog2(WIDTH/POOL)-1:0]   ox_out,
    output logic [$clog2(HEIGHT/POOL)-1:0]  oy_out
);

    localparam int OW  = WIDTH / POOL;
    localparam int OH  = HEIGHT / POOL;
    localparam int LP  = $clog2(POOL);
    localparam int AW  = DATA_W + 2 * LP;
    localparam int XW  = $clog2(WIDTH);
    localparam int YW  = $clog2(HEIGHT);
    localparam int OXW = $clog2(OW);
    localparam int OYW = $clog2(OH);

    function automatic logic [AW-1:0] extend(input logic [DATA_W-1:0] s);
        logic sbit;
        sbit = (SIGNED != 0) ? s[DATA_W-1] : 1'b0;
        return {{(2 * LP){sbit}}, s};
    endfunction

    function automatic logic [AW-1:0] combine(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                              input logic avg);
        logic gt;
        if (avg) return a + b;
        gt = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
        return gt ? a : b;
    endfunction

    // Average is a floor divide by POOL*POOL; the result is simply truncated to DATA_W.
    function automatic logic [DATA_W-1:0] finalize(input logic [AW-1:0] v, input logic avg);
        logic [AW-1:0] t;
        t = v;
        if (avg) begin
            if (SIGNED != 0) t = $signed(v) >>> (2 * LP);
            else             t = v >> (2 * LP);
        end
        return DATA_W'(t);
    endfunction

    logic [XW-1:0]               x_r;
    logic [YW-1:0]               y_r;
    logic                        mode_r;
    logic [CHANNELS-1:0][AW-1:0] h_r;
    logic [CHANNELS-1:0][AW-1:0] row_store [OW];

    logic                        sof_p0;
    logic [XW-1:0]               px_p0;
    logic [YW-1:0]               py_p0;
    logic                        mode_p0;
    logic [OXW-1:0]              ox_p0;
    logic [OYW-1:0]              oy_p0;
    logic                        in_rng_p0;
    logic                        col_end_p0;
    logic                        win_end_p0;
    logic                        last_p0;
    logic [XW-1:0]               x_nxt;
    logic [YW-1:0]               y_nxt;
    logic [CHANNELS-1:0][AW-1:0] samp_p0;
    logic [CHANNELS-1:0][AW-1:0] h_nxt_p0;
    logic [CHANNELS-1:0][AW-1:0] st_nxt_p0;
    logic [CHANNELS*DATA_W-1:0]  res_p0;

    logic                        vld_p1;
    logic [CHANNELS*DATA_W-1:0]  pix_p1;
    logic                        last_p1;
    logic [OXW-1:0]              ox_p1;
    logic [OYW-1:0]              oy_p1;

    // Stage p0: position decode, horizontal and vertical merge
    always_comb begin
        sof_p0     = valid_in && sof_in;
        px_p0      = sof_p0 ? '0 : x_r;
        py_p0      = sof_p0 ? '0 : y_r;
        mode_p0    = (px_p0 == '0 && py_p0 == '0) ? avg_mode : mode_r;
        ox_p0      = OXW'(px_p0 >> LP);
        oy_p0      = OYW'(py_p0 >> LP);
        in_rng_p0  = (int'(px_p0) < OW * POOL) && (int'(py_p0) < OH * POOL);
        col_end_p0 = valid_in && in_rng_p0 && (px_p0[LP-1:0] == LP'(POOL - 1));
        win_end_p0 = col_end_p0 && (py_p0[LP-1:0] == LP'(POOL - 1));
        last_p0    = win_end_p0 && (int'(ox_p0) == OW - 1) && (int'(oy_p0) == OH - 1);

        x_nxt = px_p0 + 1'b1;
        y_nxt = py_p0;
        if (px_p0 == XW'(WIDTH - 1)) begin
            x_nxt = '0;
            y_nxt = (py_p0 == YW'(HEIGHT - 1)) ? '0 : py_p0 + 1'b1;
        end

        samp_p0   = '0;
        h_nxt_p0  = '0;
        st_nxt_p0 = '0;
        res_p0    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            samp_p0[c]   = extend(pixel_in[c*DATA_W +: DATA_W]);
            h_nxt_p0[c]  = (px_p0[LP-1:0] == '0) ? samp_p0[c]
                                                 : combine(h_r[c], samp_p0[c], mode_p0);
            st_nxt_p0[c] = (py_p0[LP-1:0] == '0) ? h_nxt_p0[c]
                                                 : combine(row_store[ox_p0][c], h_nxt_p0[c], mode_p0);
            res_p0[c*DATA_W +: DATA_W] = finalize(st_nxt_p0[c], mode_p0);
        end
    end

    // Stage p1: registered result; outputs read zero outside the one-cycle pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_r     <= '0;
            y_r     <= '0;
            mode_r  <= 1'b0;
            h_r     <= '0;
            vld_p1  <= 1'b0;
            pix_p1  <= '0;
            last_p1 <= 1'b0;
            ox_p1   <= '0;
            oy_p1   <= '0;
        end else begin
            if (valid_in) begin
                x_r    <= x_nxt;
                y_r    <= y_nxt;
                mode_r <= mode_p0;
                h_r    <= h_nxt_p0;
            end
            vld_p1  <= win_end_p0;
            last_p1 <= last_p0;
            pix_p1  <= win_end_p0 ? res_p0 : '0;
            ox_p1   <= win_end_p0 ? ox_p0 : '0;
            oy_p1   <= win_end_p0 ? oy_p0 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && col_end_p0) row_store[ox_p0] <= st_nxt_p0;
    end

    assign valid_out = vld_p1;
    assign pixel_out = pix_p1;
    assign last_out  = last_p1;
    assign ox_out    = ox_p1;
    assign oy_out    = oy_p1;

endmodule
